// File: rtl/idli_pkg.sv
// Shared types and constants for the idli core front-end.
// The fetch unit speaks SQI (4-bit serial) to an external SRAM in sequential-read mode.
package idli_pkg;

    typedef logic [3:0] slice_t;
    typedef logic [1:0] ctr_t;

    typedef enum logic [2:0] {
        FS_DESEL,
        FS_CMD,
        FS_ADDR,
        FS_DUMMY,
        FS_DATA
    } fetch_state_t;

    localparam logic [7:0]  SQI_CMD_READ = 8'h03;
    localparam int unsigned CMD_SLICES   = 2;
    localparam int unsigned ADDR_SLICES  = 6;
    localparam int unsigned DUMMY_SLICES = 2;

endpackage

// File: rtl/idli_fetch_m.sv
// Instruction fetch front-end: runs an SQI sequential read from pc and streams
// the returned nibbles to decode as (enc, ctr, pc), restarting on redirect.
module idli_fetch_m
    import idli_pkg::*;
(
    input  logic        i_fe_gck,
    input  logic        i_fe_rst_n,
    input  logic        i_fe_redirect,
    input  logic [15:0] i_fe_redirect_pc,
    input  logic        i_fe_stall,
    output logic        o_fe_sqi_cs_n,
    output logic        o_fe_sqi_sck_en,
    output logic [3:0]  o_fe_sqi_sio_out,
    output logic        o_fe_sqi_sio_oe,
    input  logic [3:0]  i_fe_sqi_sio_in,
    output slice_t      o_fe_enc,
    output logic        o_fe_enc_vld,
    output ctr_t        o_fe_ctr,
    output logic [15:0] o_fe_pc
);

    localparam logic [2:0] CMD_LAST   = 3'(CMD_SLICES - 1);
    localparam logic [2:0] ADDR_LAST  = 3'(ADDR_SLICES - 1);
    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_SLICES - 1);

    fetch_state_t state, state_nxt;
    logic [2:0]   cyc;
    logic [15:0]  pc;
    ctr_t         ctr;
    slice_t       enc;
    logic         enc_vld;
    logic         capture;
    logic [23:0]  byte_addr;
    logic [3:0]   addr_nib;
    logic         cs_n, sck_en, sio_oe;
    logic [3:0]   sio_out;

    always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
        if (!i_fe_rst_n) begin
            state <= FS_DESEL;
            cyc   <= '0;
        end else begin
            state <= state_nxt;
            cyc   <= (state_nxt != state) ? '0 : cyc + 3'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FS_DESEL: state_nxt = FS_CMD;
            FS_CMD:   if (cyc == CMD_LAST)   state_nxt = FS_ADDR;
            FS_ADDR:  if (cyc == ADDR_LAST)  state_nxt = FS_DUMMY;
            FS_DUMMY: if (cyc == DUMMY_LAST) state_nxt = FS_DATA;
            FS_DATA:  state_nxt = FS_DATA;
            default:  state_nxt = FS_DESEL;
        endcase
        if (i_fe_redirect) state_nxt = FS_DESEL;
    end

    // pc cannot move between CMD entry and the first data slice (only a
    // redirect changes it, and that restarts in DESEL), so it doubles as the
    // latched transaction address.
    assign byte_addr = {7'b0, pc, 1'b0};

    always_comb begin
        addr_nib = '0;
        case (cyc)
            3'd0:    addr_nib = byte_addr[23:20];
            3'd1:    addr_nib = byte_addr[19:16];
            3'd2:    addr_nib = byte_addr[15:12];
            3'd3:    addr_nib = byte_addr[11:8];
            3'd4:    addr_nib = byte_addr[7:4];
            3'd5:    addr_nib = byte_addr[3:0];
            default: addr_nib = '0;
        endcase
    end

    always_comb begin
        cs_n    = 1'b1;
        sck_en  = 1'b0;
        sio_oe  = 1'b0;
        sio_out = '0;
        case (state)
            FS_CMD: begin
                cs_n    = 1'b0;
                sck_en  = 1'b1;
                sio_oe  = 1'b1;
                sio_out = (cyc == 3'd0) ? SQI_CMD_READ[7:4] : SQI_CMD_READ[3:0];
            end
            FS_ADDR: begin
                cs_n    = 1'b0;
                sck_en  = 1'b1;
                sio_oe  = 1'b1;
                sio_out = addr_nib;
            end
            FS_DUMMY: begin
                cs_n   = 1'b0;
                sck_en = 1'b1;
            end
            FS_DATA: begin
                cs_n   = 1'b0;
                sck_en = !i_fe_stall;
            end
            default: ;
        endcase
    end

    assign capture = (state == FS_DATA) && !i_fe_stall;

    // ctr/pc name the slice on o_fe_enc; they step once that slice has been shown.
    always_ff @(posedge i_fe_gck or negedge i_fe_rst_n) begin
        if (!i_fe_rst_n) begin
            pc      <= '0;
            ctr     <= '0;
            enc     <= '0;
            enc_vld <= 1'b0;
        end else if (i_fe_redirect) begin
            pc      <= i_fe_redirect_pc;
            ctr     <= '0;
            enc_vld <= 1'b0;
        end else begin
            enc_vld <= capture;
            if (capture) enc <= i_fe_sqi_sio_in;
            if (enc_vld) begin
                ctr <= ctr + 2'd1;
                if (ctr == 2'd3) pc <= pc + 16'd1;
            end
        end
    end

    assign o_fe_sqi_cs_n    = cs_n;
    assign o_fe_sqi_sck_en  = sck_en;
    assign o_fe_sqi_sio_out = sio_out;
    assign o_fe_sqi_sio_oe  = sio_oe;
    assign o_fe_enc         = enc;
    assign o_fe_enc_vld     = enc_vld;
    assign o_fe_ctr         = ctr;
    assign o_fe_pc          = pc;

endmodule
